// File: rtl/mem_stage_if.sv
// EX/MEM request bundle and MEM/WB result bundle for the memory-access stage.
// The execute side drives through the master modport; mem_stage uses the slave modport.
interface mem_stage_if;
    logic [1:0]  Mem_WB;
    logic        read_En;
    logic        write_En;
    logic [31:0] DataAddress;
    logic [31:0] WriteData;
    logic [4:0]  dest;

    logic        stall;
    logic        RegWrite;
    logic [4:0]  Write_Register;
    logic [31:0] Write_Data;
    logic [31:0] ReadData;
    logic [31:0] ALUResult;
    logic        misaligned;

    modport master (
        output Mem_WB, read_En, write_En, DataAddress, WriteData, dest,
        input  stall, RegWrite, Write_Register, Write_Data, ReadData, ALUResult, misaligned
    );

    modport slave (
        input  Mem_WB, read_En, write_En, DataAddress, WriteData, dest,
        output stall, RegWrite, Write_Register, Write_Data, ReadData, ALUResult, misaligned
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: wait-stated word memory, pipeline stall and MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN suppresses misaligned accesses and raises a sticky flag.
module mem_stage #(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input logic       clk,
    input logic       rst,
    mem_stage_if.slave bus
);
    localparam int unsigned Depth   = 2 ** DEPTH_LOG2;
    localparam logic [3:0]  WaitCnt = 4'(WAIT_STATES);
    localparam bit          HasWait = (WAIT_STATES != 0);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic stall_int;
    logic request;
    logic accept;
    logic mis_hit;
    logic mem_we;
    logic [DEPTH_LOG2-1:0] idx;

    logic [31:0] mem_q [Depth];

    logic        regwrite_q;
    logic        memtoreg_q;
    logic [4:0]  wreg_q;
    logic [31:0] readdata_q;
    logic [31:0] alu_q;
    logic        misaligned_q;

    assign request = bus.read_En | bus.write_En;
    assign idx     = bus.DataAddress[DEPTH_LOG2+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_hit = request & (bus.DataAddress[1:0] != 2'b00);
    logic unused_addr;
    assign unused_addr = ^bus.DataAddress[31:DEPTH_LOG2+2];
`else
    assign mis_hit = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{bus.DataAddress[31:DEPTH_LOG2+2], bus.DataAddress[1:0]};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_int = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (request && HasWait) begin
                    state_d   = StBusy;
                    cnt_d     = WaitCnt;
                    stall_int = 1'b1;
                end
            end
            StBusy: begin
                // cnt_q==1 is the completion cycle; guard <=1 so a stray 0 cannot wrap
                if (cnt_q <= 4'd1) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d     = cnt_q - 4'd1;
                    stall_int = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Every non-stalled cycle retires exactly one instruction into MEM/WB
    assign accept = ~stall_int;
    assign mem_we = rst & accept & bus.write_En & ~mis_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= bus.WriteData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            wreg_q     <= 5'd0;
            readdata_q <= 32'd0;
            alu_q      <= 32'd0;
        end else if (!accept) begin
            regwrite_q <= 1'b0;
        end else begin
            regwrite_q <= bus.Mem_WB[1] & ~mis_hit;
            memtoreg_q <= bus.Mem_WB[0];
            wreg_q     <= bus.dest;
            alu_q      <= bus.DataAddress;
            // Write wins over read when both enables are set
            readdata_q <= (bus.read_En && !bus.write_En && !mis_hit) ? mem_q[idx] : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misaligned_q <= 1'b0;
        end else if (accept && mis_hit) begin
            misaligned_q <= 1'b1;
        end
    end

    assign bus.stall          = rst & stall_int;
    assign bus.RegWrite       = regwrite_q;
    assign bus.Write_Register = wreg_q;
    assign bus.ReadData       = readdata_q;
    assign bus.ALUResult      = alu_q;
    assign bus.Write_Data     = memtoreg_q ? readdata_q : alu_q;
    assign bus.misaligned     = misaligned_q;
endmodule
